// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the 8-bit core control path.
// Used by the multi-cycle sequencer and the instruction decoder.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SUBI = 6'b001001;
   localparam logic [5:0] OP_LWI  = 6'b001010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000001;
   localparam logic [5:0] OP_BLT  = 6'b000011;
   localparam logic [5:0] OP_BGE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_SLT   = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT  = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OP_R, OP_ADDI, OP_SUBI, OP_LWI, OP_BEQ, OP_BNE,
         OP_BLT, OP_BGE, OP_J, OP_LW, OP_SW: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-handshake cycles; expired flags the cycle the count
// has reached LIMIT while the stall is still in progress.
module mem_wait_timer #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LIMIT_V = 8'(LIMIT);

   logic [7:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && count != LIMIT_V)
         count <= count + 8'd1;
   end

   assign expired = en && (count == LIMIT_V);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the shared-ALU, unified-memory core.
// Strobes are decoded from state (plus mem_ready/alu_zero) and forced low during reset.
module multicycle_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_load,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             fault,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired
);

   state_t state, next_state;
   logic   retire, expired, timer_en, timer_clr, taken;

   assign timer_en  = (state == S_FETCH || state == S_MEM) && !mem_ready;
   assign timer_clr = !timer_en || expired;

   mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (expired)
   );

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      taken      = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req   = rst_n;
            alu_src_b = SRCB_ONE;
            if (mem_ready) begin
               ir_load    = rst_n;
               pc_write   = rst_n;
               next_state = S_DECODE;
            end else if (expired) begin
               next_state = S_FAULT;
            end
         end
         S_DECODE: begin
            alu_src_b  = SRCB_IMM;
            next_state = is_legal(opcode) ? S_EXEC : S_FAULT;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            case (opcode)
               OP_R: begin
                  alu_op     = ALU_FUNCT;
                  next_state = S_WB;
               end
               OP_ADDI, OP_LWI, OP_SUBI: begin
                  alu_src_b  = SRCB_IMM;
                  alu_op     = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
                  next_state = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src_b  = SRCB_IMM;
                  next_state = S_MEM;
               end
               OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
                  alu_op     = (opcode == OP_BLT || opcode == OP_BGE) ? ALU_SLT : ALU_SUB;
                  taken      = alu_zero ^ (opcode == OP_BNE || opcode == OP_BLT);
                  pc_write   = taken && rst_n;
                  pc_src     = taken ? PC_BRANCH : PC_ALU;
                  next_state = S_FETCH;
               end
               OP_J: begin
                  alu_src_a  = 1'b0;
                  pc_write   = rst_n;
                  pc_src     = PC_JUMP;
                  next_state = S_FETCH;
               end
               default: begin
                  alu_src_a  = 1'b0;
                  next_state = S_FAULT;
               end
            endcase
         end
         S_MEM: begin
            mem_req = rst_n;
            iord    = 1'b1;
            mem_we  = (opcode == OP_SW) && rst_n;
            if (mem_ready)
               next_state = (opcode == OP_LW) ? S_WB : S_FETCH;
            else if (expired)
               next_state = S_FAULT;
         end
         S_WB: begin
            reg_write  = rst_n;
            reg_dst    = (opcode == OP_R);
            mem_to_reg = (opcode == OP_LW);
            next_state = S_FETCH;
         end
         default: next_state = S_FAULT;
      endcase
      retire = (next_state == S_FETCH) && (state != S_FETCH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         retired <= '0;
      end else begin
         state <= next_state;
         if (retire)
            retired <= retired + CNT_W'(1);
      end
   end

   assign fault   = (state == S_FAULT);
   assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scenario bench for multicycle_ctrl_fsm: per-cycle expected control words are
// queued as stimulus is applied and popped when the outputs are sampled.
module tb_multicycle_ctrl_fsm;
   import cpu_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       alu_zero, mem_ready;
   logic       mem_req, mem_we, iord, ir_load, pc_write, alu_src_a;
   logic       reg_write, reg_dst, mem_to_reg, fault;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [2:0] state_o;
   logic [7:0] retired;

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .alu_zero   (alu_zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_load    (ir_load),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .fault      (fault),
      .state_o    (state_o),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   typedef logic [18:0] ctl_t;

   typedef struct {
      string name;
      ctl_t  exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   // Packing order: state, mem_req, mem_we, iord, ir_load, pc_write, pc_src,
   // alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, fault.
   function automatic ctl_t mk(input logic [2:0] st, input logic req, we, io, irl, pcw,
                               input logic [1:0] pcs, input logic sa,
                               input logic [1:0] sb, op, input logic rw, rd, m2r, f);
      return {st, req, we, io, irl, pcw, pcs, sa, sb, op, rw, rd, m2r, f};
   endfunction

   ctl_t actual;
   assign actual = {state_o, mem_req, mem_we, iord, ir_load, pc_write, pc_src,
                    alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, fault};

   localparam ctl_t E_FETCH_WAIT = {3'd0, 5'b10000, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000};
   localparam ctl_t E_FETCH_RDY  = {3'd0, 5'b10011, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000};
   localparam ctl_t E_DECODE     = {3'd1, 5'b00000, 2'b00, 1'b0, 2'b10, 2'b00, 4'b0000};
   localparam ctl_t E_EXEC_R     = {3'd2, 5'b00000, 2'b00, 1'b1, 2'b00, 2'b10, 4'b0000};
   localparam ctl_t E_WB_R       = {3'd4, 5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b1100};
   localparam ctl_t E_EXEC_IMM   = {3'd2, 5'b00000, 2'b00, 1'b1, 2'b10, 2'b00, 4'b0000};
   localparam ctl_t E_WB_I       = {3'd4, 5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b1000};
   localparam ctl_t E_MEM_LW     = {3'd3, 5'b10100, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000};
   localparam ctl_t E_MEM_SW     = {3'd3, 5'b11100, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000};
   localparam ctl_t E_WB_LW      = {3'd4, 5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b1010};
   localparam ctl_t E_BR_TAKEN   = {3'd2, 5'b00001, 2'b01, 1'b1, 2'b00, 2'b01, 4'b0000};
   localparam ctl_t E_BR_NOT     = {3'd2, 5'b00000, 2'b00, 1'b1, 2'b00, 2'b01, 4'b0000};
   localparam ctl_t E_EXEC_J     = {3'd2, 5'b00001, 2'b10, 1'b0, 2'b00, 2'b00, 4'b0000};
   localparam ctl_t E_FAULT      = {3'd7, 5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0001};
   localparam ctl_t E_IN_RESET   = {3'd0, 5'b00000, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000};

   // Apply inputs for one cycle, queue the expected control word, compare at the
   // falling edge, then advance to just after the next rising edge.
   task automatic step(input string name, input logic rdy, input logic zero, input ctl_t e);
      sb_t got;
      mem_ready = rdy;
      alu_zero  = zero;
      sb_q.push_back('{name, e});
      @(negedge clk);
      got = sb_q.pop_front();
      n_checks++;
      if (actual !== got.exp) begin
         n_fail++;
         $display("FAIL %s: got %05h expected %05h (state %0d)", got.name, actual, got.exp, state_o);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      opcode    = OP_R;
      alu_zero  = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ((actual & ~ctl_t'(19'h00f0)) !== (E_IN_RESET & ~ctl_t'(19'h00f0)) || retired !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %05h/%0d expected %05h/0", actual, retired, E_IN_RESET);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_r_type;
      opcode = OP_R;
      step("r_fetch", 1'b1, 1'b0, E_FETCH_RDY);
      step("r_decode", 1'b1, 1'b0, E_DECODE);
      step("r_exec", 1'b1, 1'b0, E_EXEC_R);
      step("r_wb", 1'b1, 1'b0, E_WB_R);
      check_val("r_state_after", {5'd0, state_o}, 8'd0);
      check_val("r_retired", retired, 8'd1);
   endtask

   task automatic test_lw_wait;
      opcode = OP_LW;
      step("lw_fetch", 1'b1, 1'b0, E_FETCH_RDY);
      step("lw_decode", 1'b1, 1'b0, E_DECODE);
      step("lw_exec", 1'b1, 1'b0, E_EXEC_IMM);
      step("lw_mem_wait1", 1'b0, 1'b0, E_MEM_LW);
      step("lw_mem_wait2", 1'b0, 1'b0, E_MEM_LW);
      step("lw_mem_done", 1'b1, 1'b0, E_MEM_LW);
      step("lw_wb", 1'b1, 1'b0, E_WB_LW);
      check_val("lw_retired", retired, 8'd2);
   endtask

   task automatic test_branches;
      opcode = OP_BNE;
      step("bne_fetch", 1'b1, 1'b0, E_FETCH_RDY);
      step("bne_decode", 1'b1, 1'b0, E_DECODE);
      step("bne_exec_taken", 1'b1, 1'b0, E_BR_TAKEN);
      check_val("bne_retired", retired, 8'd3);
      opcode = OP_BEQ;
      step("beq_fetch", 1'b1, 1'b0, E_FETCH_RDY);
      step("beq_decode", 1'b1, 1'b0, E_DECODE);
      step("beq_exec_not_taken", 1'b1, 1'b0, E_BR_NOT);
      check_val("beq_state_after", {5'd0, state_o}, 8'd0);
      check_val("beq_retired", retired, 8'd4);
   endtask

   task automatic test_ready_at_limit;
      opcode = OP_ADDI;
      for (int i = 1; i <= 15; i++)
         step($sformatf("limit_wait_%0d", i), 1'b0, 1'b0, E_FETCH_WAIT);
      step("limit_ready_wins", 1'b1, 1'b0, E_FETCH_RDY);
      step("limit_decode", 1'b1, 1'b0, E_DECODE);
      step("addi_exec", 1'b1, 1'b0, E_EXEC_IMM);
      step("addi_wb", 1'b1, 1'b0, E_WB_I);
      check_val("limit_retired", retired, 8'd5);
   endtask

   task automatic test_timeout;
      opcode = OP_R;
      for (int i = 1; i <= 16; i++)
         step($sformatf("timeout_wait_%0d", i), 1'b0, 1'b0, E_FETCH_WAIT);
      step("timeout_fault", 1'b0, 1'b0, E_FAULT);
      step("timeout_sticky", 1'b1, 1'b0, E_FAULT);
      check_val("timeout_retired", retired, 8'd5);
   endtask

   task automatic test_illegal;
      test_reset();
      opcode = 6'b111111;
      step("ill_fetch", 1'b1, 1'b0, E_FETCH_RDY);
      step("ill_decode", 1'b1, 1'b0, E_DECODE);
      step("ill_fault", 1'b1, 1'b0, E_FAULT);
      step("ill_sticky", 1'b1, 1'b1, E_FAULT);
      check_val("ill_retired", retired, 8'd0);
      test_reset();
      check_val("ill_cleared_fault", {7'd0, fault}, 8'd0);
   endtask

   task automatic test_reset_mid_sw;
      opcode = OP_SW;
      step("sw_fetch", 1'b1, 1'b0, E_FETCH_RDY);
      step("sw_decode", 1'b1, 1'b0, E_DECODE);
      step("sw_exec", 1'b1, 1'b0, E_EXEC_IMM);
      step("sw_mem", 1'b1, 1'b0, E_MEM_SW);
      check_val("sw_retired", retired, 8'd1);
      step("sw2_fetch", 1'b1, 1'b0, E_FETCH_RDY);
      step("sw2_decode", 1'b1, 1'b0, E_DECODE);
      step("sw2_exec", 1'b0, 1'b0, E_EXEC_IMM);
      step("sw2_mem_wait", 1'b0, 1'b0, E_MEM_SW);
      check_val("sw2_in_mem_req", {6'd0, mem_req, mem_we}, 8'd3);
      #2 rst_n = 1'b0;
      #1;
      check_val("sw2_reset_strobes", {6'd0, mem_req, mem_we}, 8'd0);
      check_val("sw2_reset_state", {5'd0, state_o}, 8'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_val("sw2_after_state", {5'd0, state_o}, 8'd0);
      check_val("sw2_after_retired", retired, 8'd0);
   endtask

   task automatic test_wrap;
      opcode = OP_J;
      for (int i = 0; i < 256; i++) begin
         step("j_fetch", 1'b1, 1'b0, E_FETCH_RDY);
         step("j_decode", 1'b1, 1'b0, E_DECODE);
         step("j_exec", 1'b1, 1'b0, E_EXEC_J);
         if (i == 254)
            check_val("wrap_max", retired, 8'd255);
      end
      check_val("wrap_zero", retired, 8'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_r_type();
      test_lw_wait();
      test_branches();
      test_ready_at_limit();
      test_timeout();
      test_illegal();
      test_reset_mid_sw();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
